// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes. Each output channel
// has a one-word skid-free holding register and a wrapping delivered-word counter.

module demux1to4_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic [7:0]       cnt
);
  logic drain;
  assign drain = full & rdy;

  // A load wins over a drain, so a channel can refill on the edge it empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
      cnt  <= '0;
    end else begin
      if (load) begin
        full <= 1'b1;
        data <= din;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (drain) cnt <= cnt + 8'd1;
    end
  end
endmodule

module demux1to4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            load;
  logic [NUM_LANES-1:0][WIDTH-1:0] data;
  logic [NUM_LANES-1:0][7:0]       cnt;

  // Ready looks only at the addressed channel; gating with rst_n keeps it low in reset.
  assign in_ready = rst_n & (~out_valid[sel] | out_ready[sel]);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign load[k] = in_valid & in_ready & (sel == 2'(k));

    demux1to4_chan #(.WIDTH(WIDTH)) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[k]),
      .din  (in_data),
      .rdy  (out_ready[k]),
      .full (out_valid[k]),
      .data (data[k]),
      .cnt  (cnt[k])
    );
  end

  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];
  assign cnt0      = cnt[0];
  assign cnt1      = cnt[1];
  assign cnt2      = cnt[2];
  assign cnt3      = cnt[3];
endmodule

// File: tb/tb_demux1to4_reg.sv
// Scoreboard bench for demux1to4_reg: accepted words are queued per channel and
// checked against out_data when the channel drains.

module tb_demux1to4_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  demux1to4_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
  );

  always #5 clk = ~clk;

  logic [7:0] od [4];
  logic [7:0] oc [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = cnt0;
  assign oc[1] = cnt1;
  assign oc[2] = cnt2;
  assign oc[3] = cnt3;

  logic [7:0] q [4][$];
  int unsigned cnt_m [4];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model just before the edge, update model.
  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    logic       exp_rdy;
    logic [7:0] w;
    in_valid = v; sel = s; in_data = d; out_ready = r;
    #1;
    exp_rdy = rst_n && (q[s].size() == 0 || r[s]);
    chk("in_ready", in_ready, exp_rdy);
    for (int k = 0; k < 4; k++) begin
      chk("out_valid", out_valid[k], q[k].size() != 0);
      chk("cnt", oc[k], cnt_m[k] & 8'hff);
      if (q[k].size() != 0) begin
        chk("hold_data", od[k], q[k][0]);
        if (r[k]) begin
          w = q[k].pop_front();
          chk("drain_data", od[k], w);
          cnt_m[k]++;
        end
      end
    end
    if (v && exp_rdy) q[s].push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and checks the asynchronous clear.
  task automatic do_reset();
    in_valid = 1'b1; sel = 2'd0; out_ready = 4'h0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 4'h0);
    chk("rst_ready", in_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_data", od[k], 8'h00);
      chk("rst_cnt", oc[k], 8'h00);
      q[k].delete();
      cnt_m[k] = 0;
    end
    @(posedge clk);
    #1;
    chk("rst_ready_hold", in_ready, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    @(posedge clk); #1;
    do_reset();

    // Routing: one word per channel, all sinks ready.
    step(1, 2'd0, 8'h11, 4'hf);
    step(1, 2'd1, 8'h22, 4'hf);
    step(1, 2'd2, 8'h33, 4'hf);
    step(1, 2'd3, 8'h44, 4'hf);
    chk("route_d3", out_data3, 8'h44);
    step(0, 2'd0, 8'h00, 4'hf);
    step(0, 2'd0, 8'h00, 4'hf);
    chk("route_c0", cnt0, 8'd1);
    chk("route_c1", cnt1, 8'd1);
    chk("route_c2", cnt2, 8'd1);
    chk("route_c3", cnt3, 8'd1);

    // Backpressure on channel 2.
    do_reset();
    step(1, 2'd2, 8'ha5, 4'b1011);
    step(1, 2'd2, 8'hb6, 4'b1011);
    chk("bp_held", out_data2, 8'ha5);
    chk("bp_blocked", in_ready, 1'b0);
    step(1, 2'd1, 8'h77, 4'b1011);
    step(1, 2'd2, 8'hb6, 4'b1111);
    chk("bp_cnt2", cnt2, 8'd1);
    chk("bp_refill", out_data2, 8'hb6);
    step(0, 2'd0, 8'h00, 4'hf);

    // Full rate into channel 0.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 2'd0, 8'(i), 4'hf);
      chk("fr_valid", out_valid[0], 1'b1);
    end
    step(0, 2'd0, 8'h00, 4'hf);
    chk("fr_cnt0", cnt0, 8'd10);

    // Counter wrap on channel 3.
    do_reset();
    for (int i = 0; i < 256; i++) step(1, 2'd3, 8'(i), 4'hf);
    step(0, 2'd0, 8'h00, 4'hf);
    chk("wrap_cnt3", cnt3, 8'd0);
    step(1, 2'd3, 8'h5c, 4'hf);
    step(0, 2'd0, 8'h00, 4'hf);
    chk("wrap_cnt3_1", cnt3, 8'd1);

    // Async reset with held words.
    do_reset();
    step(1, 2'd0, 8'h3c, 4'h0);
    step(1, 2'd1, 8'hc3, 4'h0);
    chk("pre_rst_valid", out_valid, 4'b0011);
    do_reset();
    step(1, 2'd0, 8'h5a, 4'h0);
    chk("post_rst_load", out_data0, 8'h5a);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
    for (int i = 0; i < 3; i++) step(0, 2'd0, 8'h00, 4'hf);
    for (int k = 0; k < 4; k++) chk("rand_empty", q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/demux1to4_reg.md
DEMUX1TO4_REG -- requirements
Module: demux1to4_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width of input and each output channel.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port sel, input, 2: destination channel (0..3) for the current input word; sampled only on input handshake.
REQ-005 Port in_valid, input, 1: source presents a word.
REQ-006 Port in_ready, output, 1: block accepts the word this cycle.
REQ-007 Port in_data, input, WIDTH: input word.
REQ-008 Port out_valid, output, 4: bit k set means channel k holds a word.
REQ-009 Port out_ready, input, 4: bit k set means channel k sink takes the word this cycle.
REQ-010 Ports out_data0..out_data3, output, WIDTH each: held word of channel k.
REQ-011 Ports cnt0..cnt3, output, 8 each: delivered-word count of channel k.

Function
REQ-012 Each channel SHALL own one holding register (data + full flag); out_valid[k] SHALL equal full flag k.
REQ-013 Input handshake SHALL occur when in_valid && in_ready at a rising edge; output handshake k when out_valid[k] && out_ready[k].
REQ-014 in_ready SHALL equal !out_valid[sel] || out_ready[sel]; in_ready SHALL NOT depend on in_valid.
REQ-015 On input handshake, in_data SHALL be loaded into register sel and out_valid[sel] set; the word SHALL appear on out_data(sel) exactly 1 cycle after the handshake edge.
REQ-016 On output handshake k with no simultaneous load into k, out_valid[k] SHALL clear next cycle.
REQ-017 Simultaneous output handshake k and input handshake to k: register k SHALL take the new word, out_valid[k] SHALL stay 1 (no bubble, sustained 1 word/cycle per channel).
REQ-018 Channels SHALL be independent: a load into channel j and drains on any other channels in the same cycle SHALL all complete.
REQ-019 While out_valid[k] && !out_ready[k], out_data(k) SHALL hold stable.
REQ-020 Channels not addressed by sel SHALL be unaffected by in_valid, in_data, and sel.
REQ-021 A word SHALL never be duplicated, dropped, or routed to a channel other than the sel value at its handshake.
REQ-022 cntk SHALL increment by 1 on each output handshake k, wrapping 255 -> 0; no saturation.
REQ-023 sel changing while in_valid && !in_ready SHALL re-evaluate in_ready against the new sel in the same cycle (no lock).
REQ-024 in_ready SHALL be 0 while rst_n is low.

Reset
REQ-025 rst_n low SHALL immediately, without a clock edge, clear out_valid to 4'b0000, out_data0..3 to 0, and cnt0..3 to 0.
REQ-026 Reset asserted mid-operation SHALL discard all held words; no output handshake SHALL be counted for discarded words.
REQ-027 After rst_n rises, the first handshake SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-028 Routing: out_ready=4'b1111; send 0x11,0x22,0x33,0x44 with sel 0,1,2,3 on consecutive cycles -> each appears on out_data0..3 one cycle later, single-cycle out_valid pulse, cnt0..3 = 1.
REQ-029 Backpressure: out_ready[2]=0; send 0xA5 sel=2 -> out_valid[2]=1, out_data2=0xA5 stable; next word to sel=2 sees in_ready=0; word to sel=1 still accepted; raise out_ready[2] -> cnt2=1, sel=2 word accepted same cycle.
REQ-030 Full-rate: out_ready[0]=1, 10 back-to-back words 0x00..0x09 to sel=0 -> in_ready constantly 1, out_valid[0] continuously 1 for 10 cycles, cnt0=10, order preserved.
REQ-031 Wrap: 256 words to sel=3 with out_ready[3]=1 -> cnt3 reads 0; word 257 -> cnt3=1.
REQ-032 Async reset: channels 0 and 1 full, out_ready=0, drop rst_n between clock edges -> out_valid=0, out_data*=0, cnt*=0 immediately; in_ready=0 until rst_n high.
REQ-033 Random: random in_valid, sel, in_data, out_ready for 10k cycles vs scoreboard -> per-channel order and content match, every cntk equals scoreboard count mod 256.
